wr_flag_gen: RTL and testbench

- Write-domain flag and pointer-crossing block of the asynchronous FIFO.
- Receives the read pointer from the read domain as Gray code and synchronises it into wr_clk.
- Computes the registered full, almost_full, fill level and sticky overflow flags that gate the write controller.
- Transmits the write pointer as Gray code toward the read domain.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/wr_flag_gen_sync_chain.sv | 23 ++
 rtl/wr_flag_gen.sv | 80 ++++++++
 tb/tb_wr_flag_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width and Gray/binary conversion.
// Conversions operate on a zero-extended 32-bit value so one function
// serves any pointer width; callers truncate the result to their width.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int PTR_W          = ADDR_WIDTH_DEF + 1;

  // Binary to reflected Gray code.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB down. Zero upper bits leave
  // the result for the narrower pointer unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/wr_flag_gen_sync_chain.sv
// Multi-bit flop synchroniser with synchronous clear. Only safe for buses
// where at most one bit toggles per source cycle (Gray pointers).
module sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the asynchronous input through STAGES flops; clear all on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_flag_gen.sv
// Write-domain flag generator: syncs the Gray read pointer, derives
// look-ahead full / almost_full / level / sticky overflow, and sends the
// Gray write pointer to the read domain. All outputs are registered.
module wr_flag_gen
  import fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 14
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  wr_inc,
  input  logic [ADDR_WIDTH:0]   wr_ptr_ext,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);

  logic [PW-1:0] rd_gray_s, rd_bin_s;
  logic [PW-1:0] wr_next, lvl_next;

  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] level_q,   level_d;
  logic          full_q,    full_d;
  logic          af_q,      af_d;
  logic          ovf_q,     ovf_d;

  sync_chain #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd_sync (
    .clk   (wr_clk),
    .rst_n (rst_n),
    .d_i   (rd_ptr_gray),
    .q_o   (rd_gray_s)
  );

  // Next-state: look-ahead pointer and modular level against the synced
  // read pointer; no special case is needed at the pointer wrap.
  always_comb begin
    rd_bin_s  = PW'(gray2bin(32'(rd_gray_s)));
    wr_next   = wr_ptr_ext + PW'(wr_inc);
    lvl_next  = wr_next - rd_bin_s;
    wr_gray_d = PW'(bin2gray(32'(wr_next)));
    level_d   = lvl_next;
    full_d    = (lvl_next == DEPTH_L);
    af_d      = (lvl_next >= AF_L);
    ovf_d     = ovf_q | (wr_inc & full_q);
  end

  // Output registers, synchronously cleared.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      wr_gray_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_gray_q <= wr_gray_d;
      level_q   <= level_d;
      full_q    <= full_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_ptr_gray = wr_gray_q;
  assign wr_level    = level_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wr_flag_gen.sv
// Directed bench for wr_flag_gen (DEPTH=16, SYNC_STAGES=2, AF_THRESH=14).
module tb_wr_flag_gen;

  logic       wr_clk = 1'b0;
  logic       rst_n;
  logic       wr_inc;
  logic [4:0] wr_ptr_ext;
  logic [4:0] rd_ptr_gray;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  wr_flag_gen #(.DEPTH(16), .ADDR_WIDTH(4), .SYNC_STAGES(2), .AF_THRESH(14)) dut (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .wr_inc      (wr_inc),
    .wr_ptr_ext  (wr_ptr_ext),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock; inputs and samples happen 1ns after the rising edge.
  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_inc = 1'b0; wr_ptr_ext = 5'd0; rd_ptr_gray = 5'b00011;
    repeat (3) tick();
    checks++;
    if ({wr_ptr_gray, full, almost_full, wr_level, overflow} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got gray=%b full=%b af=%b lvl=%0d ovf=%b, want all 0",
               wr_ptr_gray, full, almost_full, wr_level, overflow);
    end
    rst_n = 1'b1;
    // Synchroniser was cleared: level stays 0 for two cycles, then sees rd=2.
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (wr_level !== 5'd0) begin
        failures++;
        $display("FAIL reset_sync_clear c%0d: wr_level=%0d want 0", i, wr_level);
      end
    end
    tick();
    checks++;
    if (wr_level !== 5'd30 || almost_full !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_sync_arrive: lvl=%0d af=%b full=%b want 30/1/0", wr_level, almost_full, full);
    end
    rd_ptr_gray = 5'd0;
    repeat (3) tick();
    checks++;
    if (wr_level !== 5'd0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_settle: lvl=%0d af=%b want 0/0", wr_level, almost_full);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr_inc = 1'b1;
      tick();
      wr_ptr_ext = wr_ptr_ext + 5'd1;
      checks++;
      if (wr_level !== 5'(i) || wr_ptr_gray !== g(5'(i)) ||
          almost_full !== (i >= 14) || full !== (i == 16)) begin
        failures++;
        $display("FAIL fill w%0d: lvl=%0d gray=%b af=%b full=%b want lvl=%0d gray=%b af=%b full=%b",
                 i, wr_level, wr_ptr_gray, almost_full, full, i, g(5'(i)), (i >= 14), (i == 16));
      end
    end
    wr_inc = 1'b0;
    tick();
    checks++;
    if (full !== 1'b1 || wr_level !== 5'd16) begin
      failures++;
      $display("FAIL fill_hold: full=%b lvl=%0d want 1/16", full, wr_level);
    end
  endtask

  task automatic test_overflow();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pre: overflow=%b want 0", overflow);
    end
    wr_inc = 1'b1;
    tick();
    wr_inc = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: overflow=%b want 1", overflow);
    end
    tick();
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1 || wr_level !== 5'd16) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b full=%b lvl=%0d want 1/1/16", overflow, full, wr_level);
    end
  endtask

  task automatic test_drain();
    rd_ptr_gray = 5'b00001;
    tick(); tick();
    checks++;
    if (full !== 1'b1 || wr_level !== 5'd16) begin
      failures++;
      $display("FAIL drain_early: full=%b lvl=%0d want 1/16", full, wr_level);
    end
    tick();
    checks++;
    if (full !== 1'b0 || wr_level !== 5'd15) begin
      failures++;
      $display("FAIL drain_release: full=%b lvl=%0d want 0/15", full, wr_level);
    end
  endtask

  task automatic test_wrap();
    rd_ptr_gray = g(5'd16);
    wr_ptr_ext  = 5'd31;
    repeat (3) tick();
    checks++;
    if (wr_level !== 5'd15 || full !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pre: lvl=%0d full=%b want 15/0", wr_level, full);
    end
    wr_inc = 1'b1;
    tick();
    wr_inc = 1'b0;
    wr_ptr_ext = 5'd0;
    checks++;
    if (wr_ptr_gray !== 5'd0 || wr_level !== 5'd16 || full !== 1'b1) begin
      failures++;
      $display("FAIL wrap_full: gray=%b lvl=%0d full=%b want 00000/16/1", wr_ptr_gray, wr_level, full);
    end
    rd_ptr_gray = g(5'd17);
    tick(); tick();
    checks++;
    if (wr_level !== 5'd16) begin
      failures++;
      $display("FAIL wrap_lag: lvl=%0d want 16", wr_level);
    end
    tick();
    checks++;
    if (wr_level !== 5'd15 || full !== 1'b0) begin
      failures++;
      $display("FAIL wrap_read: lvl=%0d full=%b want 15/0", wr_level, full);
    end
  endtask

  task automatic test_midop_reset();
    rd_ptr_gray = g(5'd23);
    repeat (3) tick();
    checks++;
    if (wr_level !== 5'd9) begin
      failures++;
      $display("FAIL midop_pre: lvl=%0d want 9", wr_level);
    end
    rst_n = 1'b0; wr_ptr_ext = 5'd0; rd_ptr_gray = 5'd0;
    tick();
    checks++;
    if ({wr_ptr_gray, full, almost_full, wr_level, overflow} !== 13'd0) begin
      failures++;
      $display("FAIL midop_reset: gray=%b full=%b af=%b lvl=%0d ovf=%b want all 0",
               wr_ptr_gray, full, almost_full, wr_level, overflow);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      wr_inc = 1'b1;
      tick();
      wr_ptr_ext = wr_ptr_ext + 5'd1;
      checks++;
      if (wr_level !== 5'(i) || wr_ptr_gray !== g(5'(i)) || overflow !== 1'b0) begin
        failures++;
        $display("FAIL midop_resume w%0d: lvl=%0d gray=%b ovf=%b want %0d/%b/0",
                 i, wr_level, wr_ptr_gray, overflow, i, g(5'(i)));
      end
    end
    wr_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
